// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// fir_serial_mac : direct-form FIR, one shared multiplier, act/ready handshake
// Revision: 1.0
// ============================================================================
module fir_serial_mac #(
  parameter int                 DW    = 16,
  parameter int                 CW    = 16,
  parameter int                 TAPS  = 4,
  parameter logic [TAPS*CW-1:0] COEFS = {16'd4, 16'd3, 16'd2, 16'd1},
  parameter int                 SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic signed [DW-1:0] x,
  input  logic                 act,
  output logic signed [DW-1:0] y,
  output logic                 ready,
  output logic                 sat
);

  localparam int ACCW = DW + CW + $clog2(TAPS);
  localparam int KW   = $clog2(TAPS);
  // k counts one past the last tap so it never wraps during MAC
  localparam int KCW  = $clog2(TAPS + 1);

  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0]    d [TAPS];
  logic signed [ACCW-1:0]  acc;
  logic [KCW-1:0]          k;

  logic                    accept;
  logic [KW-1:0]           kidx;
  logic signed [CW-1:0]    h_k;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    y_c;
  logic                    sat_c;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (act) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC:     if (k == KCW'(TAPS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiplier: coefficient and delay tap both selected by k
  assign kidx     = k[KW-1:0];
  assign h_k      = COEFS[kidx*CW +: CW];
  assign prod     = h_k * d[kidx];
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
  assign shifted  = acc >>> SHIFT;

  always_comb begin
    y_c   = shifted[DW-1:0];
    sat_c = 1'b0;
    if (shifted > YMAX) begin
      y_c   = YMAX[DW-1:0];
      sat_c = 1'b1;
    end else if (shifted < YMIN) begin
      y_c   = YMIN[DW-1:0];
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
      acc <= '0;
      k   <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else begin
      if (accept) begin
        d[0] <= x;
        for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= acc + prod_ext;
        k   <= k + 1'b1;
      end else if (state == DONE) begin
        y   <= y_c;
        sat <= sat_c;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// Testbench for fir_serial_mac: reference FIR model feeds a scoreboard queue,
// outputs are popped and compared when ready returns.
module tb_fir_serial_mac;

  logic               clk = 1'b0;
  logic               reset_p = 1'b1;
  logic signed [15:0] x = '0;
  logic               act = 1'b0;
  logic signed [15:0] y;
  logic               ready;
  logic               sat;

  int n_vec = 0;
  int n_err = 0;

  int hist [4];
  int coef [4] = '{1, 2, 3, 4};
  int exp_y_q [$];
  int exp_s_q [$];

  fir_serial_mac dut (
    .clk     (clk),
    .reset_p (reset_p),
    .x       (x),
    .act     (act),
    .y       (y),
    .ready   (ready),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_push(input int xin);
    longint sum;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = xin;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += longint'(coef[i]) * hist[i];
    if (sum > 32767) begin
      exp_y_q.push_back(32767);  exp_s_q.push_back(1);
    end else if (sum < -32768) begin
      exp_y_q.push_back(-32768); exp_s_q.push_back(1);
    end else begin
      exp_y_q.push_back(int'(sum)); exp_s_q.push_back(0);
    end
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    #50;
    check("rst_ready", ready, 1);
    check("rst_y", y, 0);
    check("rst_sat", sat, 0);
    #50;
    reset_p = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    exp_y_q.delete();
    exp_s_q.delete();
    @(posedge clk); #1;
  endtask

  // Offer one sample when ready; leaves act high if hold is set.
  task automatic accept(input int xin, input bit hold);
    int w;
    w = 0;
    while (!ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) check("wait_ready_timeout", w, 0);
    x   = 16'(xin);
    act = 1'b1;
    model_push(xin);
    @(posedge clk); #1;
    if (!hold) act = 1'b0;
    check("ready_low_after_accept", ready, 0);
  endtask

  // Count busy cycles, optionally fire a stray act at E2, then score the result.
  task automatic finish_sample(input bit busy);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 20) begin
      if (busy && cnt == 1) begin act = 1'b1; x = 16'sd999; end
      else if (busy && cnt == 2) act = 1'b0;
      @(posedge clk); #1; cnt++;
    end
    check("busy_cycles", cnt, 5);
    if (exp_y_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      check("y", y, exp_y_q.pop_front());
      check("sat", sat, exp_s_q.pop_front());
    end
  endtask

  initial begin
    int stream [4] = '{100, 200, 300, 400};

    // Reset state
    do_reset();
    check("idle_ready", ready, 1);
    check("idle_y", y, 0);

    // Plain stream
    foreach (stream[i]) begin
      accept(stream[i], 1'b0);
      finish_sample(1'b0);
    end

    // Same stream with a stray act during sample 2's MAC phase
    do_reset();
    foreach (stream[i]) begin
      accept(stream[i], 1'b0);
      finish_sample(i == 1);
    end

    // Positive then negative saturation
    do_reset();
    repeat (2) begin accept(32767, 1'b0); finish_sample(1'b0); end
    do_reset();
    repeat (2) begin accept(-32768, 1'b0); finish_sample(1'b0); end

    // Reset mid-MAC
    do_reset();
    accept(200, 1'b0);
    @(posedge clk);
    @(posedge clk);
    reset_p = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_y", y, 0);
    check("midrst_sat", sat, 0);
    do_reset();
    accept(100, 1'b0);
    finish_sample(1'b0);

    // act tied high: back-to-back accepts every TAPS+2 cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      accept(100, 1'b1);
      finish_sample(1'b0);
    end
    act = 1'b0;
    check("sb_drained", exp_y_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
